// File: rtl/sync_mem_multiport.sv
// sync_mem_multiport: byte-addressed scratch memory with NUM_WR byte-masked
// write ports and NUM_RD registered read ports. A clear engine zeroes the
// array one word per cycle after reset. Traffic is accepted only once
// `ready` is high.
// Optional macro SYNC_MEM_WR_BYPASS_EN: makes reads write-first by
// forwarding each same-cycle written byte. Without it, reads are read-first.
module sync_mem_multiport #(
    parameter int NUM_BYTES  = 1 << 21,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    localparam int ADDR_W    = $clog2(NUM_BYTES),
    localparam int MASK_W    = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WR*MASK_W-1:0]     wr_mask,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic                         ready
);

    localparam int NUM_WORDS = NUM_BYTES / MASK_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        clr_idx_q, clr_idx_d;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]       rd_valid_q, rd_valid_d;

    logic [7:0]              mem [NUM_BYTES];

    logic                    clr_we;
    logic [ADDR_W-1:0]       clr_base;
    logic [ADDR_W-1:0]       wr_byte_addr [NUM_WR][MASK_W];
    logic [7:0]              wr_byte_data [NUM_WR][MASK_W];
    logic                    wr_byte_en   [NUM_WR][MASK_W];
    logic [ADDR_W-1:0]       rd_byte_addr [NUM_RD][MASK_W];

    // Clear FSM: walk every word once, then park in READY until reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end
    end

    // Per-byte write/read addresses (wrapping mod NUM_BYTES) and write strobes.
    always_comb begin
        clr_we   = (state_q == ST_CLEAR) && !reset;
        clr_base = ADDR_W'(clr_idx_q) * ADDR_W'(MASK_W);
        for (int k = 0; k < NUM_WR; k++) begin
            for (int i = 0; i < MASK_W; i++) begin
                wr_byte_addr[k][i] = wr_addr[k*ADDR_W +: ADDR_W] + ADDR_W'(i);
                wr_byte_data[k][i] = wr_data[k*DATA_WIDTH + i*8 +: 8];
                wr_byte_en[k][i]   = wr_en[k] && wr_mask[k*MASK_W + i]
                                     && (state_q == ST_READY) && !reset;
            end
        end
        for (int j = 0; j < NUM_RD; j++) begin
            for (int i = 0; i < MASK_W; i++) begin
                rd_byte_addr[j][i] = rd_addr[j*ADDR_W +: ADDR_W] + ADDR_W'(i);
            end
        end
    end

    // Read path: gather bytes for each enabled port; hold data when idle.
    always_comb begin
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (state_q == ST_CLEAR) begin
            rd_data_d = '0;
        end else begin
            for (int j = 0; j < NUM_RD; j++) begin
                if (rd_en[j]) begin
                    rd_valid_d[j] = 1'b1;
                    for (int i = 0; i < MASK_W; i++) begin
                        rd_data_d[j*DATA_WIDTH + i*8 +: 8] = mem[rd_byte_addr[j][i]];
`ifdef SYNC_MEM_WR_BYPASS_EN
                        // Later ports override earlier ones, matching write priority.
                        for (int k = 0; k < NUM_WR; k++) begin
                            for (int m = 0; m < MASK_W; m++) begin
                                if (wr_byte_en[k][m] && (wr_byte_addr[k][m] == rd_byte_addr[j][i])) begin
                                    rd_data_d[j*DATA_WIDTH + i*8 +: 8] = wr_byte_data[k][m];
                                end
                            end
                        end
`endif
                    end
                end
            end
        end
    end

    // Array update: clear engine in CLEAR, port writes in READY; the last
    // non-blocking assignment to a byte wins, so higher ports take priority.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the clear engine zeroes it word by word instead.
        if (clr_we) begin
            for (int i = 0; i < MASK_W; i++) begin
                mem[clr_base + ADDR_W'(i)] <= 8'h00;
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wr_byte_en[k][i]) begin
                    mem[wr_byte_addr[k][i]] <= wr_byte_data[k][i];
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ready    = (state_q == ST_READY);

endmodule

// File: tb/tb_sync_mem_multiport.sv
// Self-checking bench for sync_mem_multiport: directed clear/reset/write/read
// scenarios followed by random traffic, compared against a byte-array model.
module tb_sync_mem_multiport;

    localparam int NB = 64;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 6;
    localparam int MW = 4;
`ifdef SYNC_MEM_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NW*MW-1:0]  wr_mask;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_valid;
    logic              ready;

    sync_mem_multiport #(
        .NUM_BYTES (NB),
        .DATA_WIDTH(DW),
        .NUM_RD    (NR),
        .NUM_WR    (NW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_mask (wr_mask),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]    m_mem [NB];
    bit            m_clearing = 1'b1;
    int            m_clr = 0;
    logic [DW-1:0] m_rd [NR];
    logic [NR-1:0] m_vld = '0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_port(input int j);
        return rd_data[j*DW +: DW];
    endfunction

    task automatic set_wr(input int k, input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        wr_en[k]             = 1'b1;
        wr_addr[k*AW +: AW]  = AW'(a);
        wr_data[k*DW +: DW]  = d;
        wr_mask[k*MW +: MW]  = m;
    endtask

    task automatic set_rd(input int j, input int a);
        rd_en[j]            = 1'b1;
        rd_addr[j*AW +: AW] = AW'(a);
    endtask

    // Apply the behavioural rules to the inputs present before the edge.
    task automatic model_step();
        logic [7:0] old [NB];
        if (reset) begin
            m_clearing = 1'b1;
            m_clr      = 0;
            m_vld      = '0;
            for (int j = 0; j < NR; j++) m_rd[j] = '0;
        end else if (m_clearing) begin
            for (int i = 0; i < MW; i++) m_mem[m_clr*MW + i] = 8'h00;
            m_clr++;
            if (m_clr == NB / MW) m_clearing = 1'b0;
            m_vld = '0;
            for (int j = 0; j < NR; j++) m_rd[j] = '0;
        end else begin
            old = m_mem;
            for (int k = 0; k < NW; k++) begin
                if (wr_en[k]) begin
                    for (int i = 0; i < MW; i++) begin
                        if (wr_mask[k*MW + i])
                            m_mem[(int'(wr_addr[k*AW +: AW]) + i) % NB] = wr_data[k*DW + i*8 +: 8];
                    end
                end
            end
            for (int j = 0; j < NR; j++) begin
                m_vld[j] = rd_en[j];
                if (rd_en[j]) begin
                    for (int i = 0; i < MW; i++) begin
                        int a;
                        a = (int'(rd_addr[j*AW +: AW]) + i) % NB;
                        m_rd[j][i*8 +: 8] = BYPASS ? m_mem[a] : old[a];
                    end
                end
            end
        end
    endtask

    // One clock: update model, clock the DUT, compare every output, clear strobes.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("ready", 32'(ready), 32'(!m_clearing));
        for (int j = 0; j < NR; j++) begin
            check($sformatf("rd_valid%0d", j), 32'(rd_valid[j]), 32'(m_vld[j]));
            check($sformatf("rd_data%0d", j), rd_port(j), m_rd[j]);
        end
        reset = 1'b0;
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic random_traffic();
        for (int k = 0; k < NW; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                int a;
                a = ($urandom_range(0, 2) == 0) ? 8 : int'($urandom_range(0, NB - 1));
                set_wr(k, a, $urandom, MW'($urandom));
            end
        end
        for (int j = 0; j < NR; j++) begin
            if ($urandom_range(0, 1) == 1) begin
                int a;
                a = ($urandom_range(0, 2) == 0) ? 8 : int'($urandom_range(0, NB - 1));
                set_rd(j, a);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        rd_en   = '0;
        rd_addr = '0;
        for (int j = 0; j < NR; j++) m_rd[j] = '0;
        for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;

        // Initial reset and clear
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_valid", 32'(rd_valid), 32'h0);
        for (int c = 1; c <= 16; c++) tick();

        // Preload nonzero contents, then pulse reset and watch the clear
        for (int w = 0; w < NB / MW; w++) begin
            set_wr(0, w * MW, $urandom | 32'h0101_0101, 4'hF);
            tick();
        end
        reset = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("clear_ready_edge", 32'(ready), 32'(c == 16));
        end
        for (int w = 0; w < NB / MW; w++) begin
            set_rd(0, w * MW);
            set_rd(1, w * MW);
            tick();
            check("cleared_word", rd_port(0), 32'h0);
        end

        // Reset in the middle of a clear; writes/reads during clear are ignored
        for (int w = 0; w < NB / MW; w++) begin
            set_wr(1, w * MW, 32'hA5A5_A5A5, 4'hF);
            tick();
        end
        reset = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) tick();
        reset = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            set_wr(0, (c % 16) * MW, 32'hFFFF_FFFF, 4'hF);
            set_wr(1, 0, 32'h1234_5678, 4'hF);
            set_rd(0, 0);
            tick();
            check("midclr_ready_edge", 32'(ready), 32'(c == 16));
            check("midclr_rd_valid", 32'(rd_valid), 32'h0);
        end
        for (int w = 0; w < NB / MW; w++) begin
            set_rd(1, w * MW);
            tick();
            check("midclr_word", rd_port(1), 32'h0);
        end

        // Masked, unaligned write that wraps past the top of the array
        set_wr(0, 62, 32'hDDCC_BBAA, 4'b1011);
        tick();
        set_rd(0, 62);
        set_rd(1, 0);
        tick();
        check("wrap_read62", rd_port(0), 32'hDD00_BBAA);
        check("wrap_read0", rd_port(1), 32'h0000_DD00);

        // Same-byte conflict: port1 owns the low two bytes
        set_wr(0, 8, 32'h1111_1111, 4'hF);
        set_wr(1, 8, 32'h2222_2222, 4'h3);
        tick();
        set_rd(0, 8);
        tick();
        check("conflict", rd_port(0), 32'h1111_2222);

        // Same-cycle write and read of one word
        set_wr(0, 16, 32'hCAFE_F00D, 4'hF);
        set_rd(0, 16);
        tick();
        check("order_same_cycle", rd_port(0), BYPASS ? 32'hCAFE_F00D : 32'h0);
        set_rd(0, 16);
        tick();
        check("order_next_read", rd_port(0), 32'hCAFE_F00D);

        // Read once, then hold while the word is rewritten
        set_rd(1, 8);
        tick();
        check("hold_first_valid", 32'(rd_valid[1]), 32'h1);
        check("hold_first_data", rd_port(1), 32'h1111_2222);
        for (int c = 0; c < 3; c++) begin
            set_wr(0, 8, 32'h5555_0000 + 32'(c), 4'hF);
            tick();
            check("hold_valid_low", 32'(rd_valid[1]), 32'h0);
            check("hold_data", rd_port(1), 32'h1111_2222);
        end

        // Random traffic with a reset dropped in part-way
        for (int n = 0; n < 400; n++) begin
            if (n == 200) reset = 1'b1;
            else random_traffic();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
